// File: rtl/line_buffer_ctrl_pkg.sv
// line_buffer_ctrl_pkg: bank-state encoding and default scanline geometry shared by the
// line buffer controller and vga_top.
package line_buffer_ctrl_pkg;

    // Default geometry: 800 active pixels per line, 10-bit address per bank.
    localparam int unsigned LBC_LINE_LEN = 800;
    localparam int unsigned LBC_AW       = 10;

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
    typedef enum logic [1:0] {
        BsEmpty   = 2'd0,
        BsFilling = 2'd1,
        BsFull    = 2'd2,
        BsReading = 2'd3
    } bank_state_e;

    // A bank can take pixels only while it is empty or part-written.
    function automatic logic bank_writable(logic [1:0] st);
        return (st == BsEmpty) || (st == BsFilling);
    endfunction

endpackage

// File: rtl/lbc_bank_state.sv
// lbc_bank_state: state register for one scanline bank. The controller never raises two
// events for the same bank in one cycle, so the priority order below only matters for flush.
module lbc_bank_state
    import line_buffer_ctrl_pkg::*;
(
    input  logic       pclk,
    input  logic       rst,
    input  logic       flush,
    input  logic       set_fill,
    input  logic       set_full,
    input  logic       claim,
    input  logic       rel,
    output logic [1:0] state
);

    // Bank lifecycle register; reset and flush both discard the bank contents.
    always_ff @(posedge pclk) begin
        if (rst || flush) begin
            state <= BsEmpty;
        end else if (set_full) begin
            state <= BsFull;
        end else if (set_fill) begin
            state <= BsFilling;
        end else if (claim) begin
            state <= BsReading;
        end else if (rel) begin
            state <= BsEmpty;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: ping-pong scheduler for the two-bank scanline buffer between the PPU
// pixel stream and the video output path. Handles line doubling (each stored line is served
// REPEAT times) and flags underruns.
// Optional build macro LBC_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int unsigned LINE_LEN = LBC_LINE_LEN,
    parameter int unsigned AW       = LBC_AW,
    parameter int unsigned REPEAT   = 2
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          wr_line_done,
    input  logic          rd_line_start,
    input  logic          rd_pix_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          underrun
`ifdef LBC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam logic [AW-1:0] LastAddr = AW'(LINE_LEN - 1);
    localparam logic [1:0]    LastRep  = 2'(REPEAT - 1);

    logic [1:0] bs [2];
    logic       rd_ptr;
    logic [1:0] rep_cnt;

    logic       wr_last;
    logic       rd_any_reading;
    logic       rd_repeat;
    logic       rd_claim;
    logic [1:0] set_fill;
    logic [1:0] set_full;
    logic [1:0] claim;
    logic [1:0] rel;

    // Writer may only target a bank that is empty or part-written.
    assign wr_ready = bank_writable(bs[wr_bank]);
    assign wr_en    = wr_valid & wr_ready;
    assign wr_last  = wr_en && (wr_addr == LastAddr);

    // Decode write/read events into per-bank state commands. Flush is handled inside the
    // bank registers, where it overrides every command.
    always_comb begin
        set_fill = '0;
        set_full = '0;
        claim    = '0;
        rel      = '0;

        rd_any_reading = (bs[0] == BsReading) || (bs[1] == BsReading);
        rd_repeat      = rd_line_start && rd_any_reading && (rep_cnt != LastRep);
        rd_claim       = rd_line_start && !rd_repeat && (bs[rd_ptr] == BsFull);

        for (int b = 0; b < 2; b++) begin
            set_fill[b] = wr_en && !wr_last && (wr_bank == 1'(b));
            set_full[b] = wr_last && (wr_bank == 1'(b));
            rel[b]      = rd_line_start && !rd_repeat && (bs[b] == BsReading);
            claim[b]    = rd_claim && (rd_ptr == 1'(b));
        end
    end

    lbc_bank_state u_bank0 (
        .pclk     (pclk),
        .rst      (rst),
        .flush    (flush),
        .set_fill (set_fill[0]),
        .set_full (set_full[0]),
        .claim    (claim[0]),
        .rel      (rel[0]),
        .state    (bs[0])
    );

    lbc_bank_state u_bank1 (
        .pclk     (pclk),
        .rst      (rst),
        .flush    (flush),
        .set_fill (set_fill[1]),
        .set_full (set_full[1]),
        .claim    (claim[1]),
        .rel      (rel[1]),
        .state    (bs[1])
    );

    // Write pointer: advance on accept, hop to the other bank after the last pixel.
    always_ff @(posedge pclk) begin
        if (rst || flush) begin
            wr_addr      <= '0;
            wr_bank      <= 1'b0;
            wr_line_done <= 1'b0;
        end else begin
            wr_line_done <= wr_last;
            if (wr_last) begin
                wr_addr <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Read scheduler: repeat, claim the next full bank, or underrun at each line start;
    // between line starts the address follows the pixel strobe and sticks at the last pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_bank  <= 1'b0;
            rd_ptr   <= 1'b0;
            rd_addr  <= '0;
            rep_cnt  <= '0;
            rd_valid <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            // rd_bank is left alone; rd_valid low already blanks the output.
            rd_ptr   <= 1'b0;
            rd_addr  <= '0;
            rep_cnt  <= '0;
            rd_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= rd_line_start && !rd_repeat && !rd_claim;
            if (rd_repeat) begin
                rep_cnt <= rep_cnt + 1'b1;
                rd_addr <= '0;
            end else if (rd_claim) begin
                rd_bank  <= rd_ptr;
                rd_ptr   <= ~rd_ptr;
                rep_cnt  <= '0;
                rd_addr  <= '0;
                rd_valid <= 1'b1;
            end else if (rd_line_start) begin
                rep_cnt  <= '0;
                rd_addr  <= '0;
                rd_valid <= 1'b0;
            end else if (rd_pix_en && rd_valid && (rd_addr != LastAddr)) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

`ifdef LBC_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses; survives flush so vsync does not hide history.
    always_ff @(posedge pclk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
